// File: rtl/mnist_window_gen.sv
// Streams a 28x28 image into a 5-row ring line buffer and issues every KxK window on START/IMGIN/X/Y.
// Define MNIST_WINGEN_BINARIZE_EN to store pixels thresholded to 8'hFF/8'h00 at 8'h80.
module mnist_window_gen #(
    parameter int unsigned IMG_W = 28,
    parameter int unsigned IMG_H = 28,
    parameter int unsigned K     = 5,
    parameter int unsigned PIX_W = 8
) (
    input  logic                 CLK,
    input  logic                 nRST,
    input  logic                 PIX_VALID,
    input  logic [PIX_W-1:0]     PIX_DATA,
    output logic                 PIX_READY,
    output logic                 START,
    output logic [4:0]           X,
    output logic [4:0]           Y,
    output logic [K*K*PIX_W-1:0] IMGIN,
    input  logic                 DONE,
    output logic                 FRAME_DONE
);
    localparam int unsigned SlotW = $clog2(K);
    localparam int unsigned ColW  = $clog2(IMG_W);
    localparam logic [4:0]       LastX    = 5'(IMG_H - K);
    localparam logic [4:0]       LastY    = 5'(IMG_W - K);
    localparam logic [ColW-1:0]  LastCol  = ColW'(IMG_W - 1);
    localparam logic [SlotW-1:0] LastSlot = SlotW'(K - 1);

    typedef enum logic [2:0] {StIdle, StFill, StLoad, StStrt, StWait, StRow} state_e;

    state_e               state_q, state_d;
    logic [SlotW-1:0]     fill_row_q, fill_row_d;
    logic [ColW-1:0]      col_q, col_d;
    logic [SlotW-1:0]     base_q, base_d;  // slot holding image row cur_x
    logic [4:0]           cur_x_q, cur_x_d;
    logic [4:0]           cur_y_q, cur_y_d;
    logic [4:0]           x_q, x_d;
    logic [4:0]           y_q, y_d;
    logic [K*K*PIX_W-1:0] imgin_q, imgin_d;
    logic                 frame_done_q, frame_done_d;

    logic [PIX_W-1:0]     ring_q [K][IMG_W];
    logic [SlotW-1:0]     win_slot [K];
    logic [K*K*PIX_W-1:0] window;
    logic [PIX_W-1:0]     wr_data;
    logic [SlotW-1:0]     wr_slot;
    logic                 accept;

    assign PIX_READY  = (state_q == StFill) || (state_q == StRow);
    assign START      = (state_q == StStrt);
    assign X          = x_q;
    assign Y          = y_q;
    assign IMGIN      = imgin_q;
    assign FRAME_DONE = frame_done_q;
    assign accept     = PIX_VALID && PIX_READY;
    // Row X+5 lands in slot (X+5) mod 5, which is the slot row X is leaving.
    assign wr_slot    = (state_q == StRow) ? base_q : fill_row_q;

`ifdef MNIST_WINGEN_BINARIZE_EN
    assign wr_data = PIX_DATA[PIX_W-1] ? '1 : '0;
`else
    assign wr_data = PIX_DATA;
`endif

    always_ff @(posedge CLK) begin
        if (accept) begin
            ring_q[wr_slot][col_q] <= wr_data;
        end
    end

    always_comb begin
        for (int i = 0; i < int'(K); i++) begin
            if (int'(base_q) + i >= int'(K)) begin
                win_slot[i] = SlotW'(int'(base_q) + i - int'(K));
            end else begin
                win_slot[i] = SlotW'(int'(base_q) + i);
            end
        end
    end

    always_comb begin : p_window
        logic [5:0] col6;
        col6   = '0;
        window = '0;
        for (int i = 0; i < int'(K); i++) begin
            for (int j = 0; j < int'(K); j++) begin
                col6 = {1'b0, cur_y_q} + 6'(j);
                window[(i*K+j)*PIX_W +: PIX_W] = ring_q[win_slot[i]][col6[ColW-1:0]];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        fill_row_d   = fill_row_q;
        col_d        = col_q;
        base_d       = base_q;
        cur_x_d      = cur_x_q;
        cur_y_d      = cur_y_q;
        x_d          = x_q;
        y_d          = y_q;
        imgin_d      = imgin_q;
        frame_done_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                fill_row_d = '0;
                col_d      = '0;
                base_d     = '0;
                cur_x_d    = '0;
                cur_y_d    = '0;
                state_d    = StFill;
            end
            StFill: begin
                if (accept) begin
                    if (col_q == LastCol) begin
                        col_d      = '0;
                        fill_row_d = fill_row_q + 1'b1;
                        if (fill_row_q == LastSlot) begin
                            state_d = StLoad;
                        end
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            StLoad: begin
                x_d     = cur_x_q;
                y_d     = cur_y_q;
                imgin_d = window;
                state_d = StStrt;
            end
            StStrt: state_d = StWait;
            StWait: begin
                if (DONE) begin
                    if (cur_y_q != LastY) begin
                        cur_y_d = cur_y_q + 5'd1;
                        state_d = StLoad;
                    end else if (cur_x_q != LastX) begin
                        state_d = StRow;
                    end else begin
                        frame_done_d = 1'b1;
                        state_d      = StIdle;
                    end
                end
            end
            StRow: begin
                if (accept) begin
                    if (col_q == LastCol) begin
                        col_d   = '0;
                        cur_x_d = cur_x_q + 5'd1;
                        cur_y_d = '0;
                        base_d  = (base_q == LastSlot) ? '0 : base_q + 1'b1;
                        state_d = StLoad;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q      <= StIdle;
            fill_row_q   <= '0;
            col_q        <= '0;
            base_q       <= '0;
            cur_x_q      <= '0;
            cur_y_q      <= '0;
            x_q          <= '0;
            y_q          <= '0;
            imgin_q      <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            fill_row_q   <= fill_row_d;
            col_q        <= col_d;
            base_q       <= base_d;
            cur_x_q      <= cur_x_d;
            cur_y_q      <= cur_y_d;
            x_q          <= x_d;
            y_q          <= y_d;
            imgin_q      <= imgin_d;
            frame_done_q <= frame_done_d;
        end
    end

endmodule

// File: tb/tb_mnist_window_gen.sv
// Directed bench for mnist_window_gen: ramp frames, handshake timing, row refill, mid-frame reset.
`timescale 1ns/1ps
module tb_mnist_window_gen;
    localparam int K     = 5;
    localparam int Bound = 20000;
`ifdef MNIST_WINGEN_BINARIZE_EN
    localparam logic [7:0] ExpW00B0  = 8'h00;
    localparam logic [7:0] ExpW00B5  = 8'h00;
    localparam logic [7:0] ExpW00B24 = 8'h00;
    localparam logic [7:0] ExpLastB0 = 8'hFF;
    localparam logic [7:0] ExpLastB24 = 8'h00;
    localparam logic [7:0] ExpW10B24 = 8'hFF;
`else
    localparam logic [7:0] ExpW00B0  = 8'h00;
    localparam logic [7:0] ExpW00B5  = 8'h1C;
    localparam logic [7:0] ExpW00B24 = 8'h74;
    localparam logic [7:0] ExpLastB0 = 8'h9B;
    localparam logic [7:0] ExpLastB24 = 8'h0F;
    localparam logic [7:0] ExpW10B24 = 8'h90;
`endif

    logic         CLK = 1'b0;
    logic         nRST;
    logic         PIX_VALID;
    logic [7:0]   PIX_DATA;
    logic         PIX_READY;
    logic         START;
    logic [4:0]   X;
    logic [4:0]   Y;
    logic [199:0] IMGIN;
    logic         DONE;
    logic         FRAME_DONE;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int pix_idx = 0;
    bit feed_en = 0, gap_en = 0, gap_tog = 0, auto_done = 0, acc_q = 0;
    int done_cd = 0;
    int start_cnt = 0, fd_cnt = 0, win_err = 0, order_err = 0;
    int ex = 0, ey = 0;
    int first_start_cyc = 0, acc140_cyc = 0, last_start_cyc = 0, fd_cyc = -100;
    logic rdy_at_fd = 1'b1, rdy_after_fd = 1'b0;
    logic [7:0] w00_b0, w00_b5, w00_b24, wl_b0, wl_b24, w10_b24;
    bit refill_on = 0;
    int refill_cnt = 0, refill_last = 0, refill_acc_cyc = 0, w10_cyc = 0;
    logic [4:0] last_x, last_y;

    mnist_window_gen dut (
        .CLK       (CLK),
        .nRST      (nRST),
        .PIX_VALID (PIX_VALID),
        .PIX_DATA  (PIX_DATA),
        .PIX_READY (PIX_READY),
        .START     (START),
        .X         (X),
        .Y         (Y),
        .IMGIN     (IMGIN),
        .DONE      (DONE),
        .FRAME_DONE(FRAME_DONE)
    );

    always #5 CLK = ~CLK;

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    function automatic logic [7:0] pix_model(input int r, input int c);
        logic [7:0] v;
        v = 8'((r * 28 + c) % 256);
`ifdef MNIST_WINGEN_BINARIZE_EN
        v = (v >= 8'h80) ? 8'hFF : 8'h00;
`endif
        return v;
    endfunction

    // Input driver, just after each rising edge.
    initial begin
        forever begin
            @(posedge CLK);
            #1;
            cyc++;
            if (acc_q) pix_idx++;
            gap_tog   = ~gap_tog;
            PIX_VALID = feed_en && (!gap_en || gap_tog);
            PIX_DATA  = 8'((pix_idx % 784) % 256);
            if (auto_done) begin
                DONE = (done_cd == 1);
                if (done_cd > 0) done_cd--;
            end else begin
                done_cd = 0;
            end
        end
    end

    // Output monitor and window model, on the falling edge.
    initial begin
        forever begin
            @(negedge CLK);
            acc_q = PIX_VALID && PIX_READY;
            if (acc_q && (pix_idx % 784) == 139) acc140_cyc = cyc;
            if (acc_q && refill_on) begin
                refill_cnt++;
                refill_acc_cyc = cyc;
            end
            if (FRAME_DONE) begin
                fd_cnt++;
                fd_cyc = cyc;
            end
            if (cyc == fd_cyc) rdy_at_fd = PIX_READY;
            if (cyc == fd_cyc + 1) rdy_after_fd = PIX_READY;
            if (START) begin
                start_cnt++;
                last_start_cyc = cyc;
                last_x = X;
                last_y = Y;
                if (auto_done) done_cd = 2;
                if (int'(X) != ex || int'(Y) != ey) order_err++;
                for (int i = 0; i < K; i++) begin
                    for (int j = 0; j < K; j++) begin
                        if (IMGIN[(i*K+j)*8 +: 8] != pix_model(int'(X) + i, int'(Y) + j)) win_err++;
                    end
                end
                if (X == 5'd0 && Y == 5'd0) begin
                    first_start_cyc = cyc;
                    w00_b0  = IMGIN[7:0];
                    w00_b5  = IMGIN[47:40];
                    w00_b24 = IMGIN[199:192];
                end
                if (X == 5'd23 && Y == 5'd23) begin
                    wl_b0  = IMGIN[7:0];
                    wl_b24 = IMGIN[199:192];
                end
                if (X == 5'd0 && Y == 5'd23) begin
                    refill_on  = 1;
                    refill_cnt = 0;
                end
                if (X == 5'd1 && Y == 5'd0) begin
                    refill_on   = 0;
                    refill_last = refill_cnt;
                    w10_b24     = IMGIN[199:192];
                    w10_cyc     = cyc;
                end
                if (ey == 23) begin
                    ey = 0;
                    ex = (ex == 23) ? 0 : ex + 1;
                end else begin
                    ey++;
                end
            end
        end
    end

    task automatic check_idle_outputs(input string pfx);
        check_val({pfx, "_start"}, int'(START), 0);
        check_val({pfx, "_frame_done"}, int'(FRAME_DONE), 0);
        check_val({pfx, "_pix_ready"}, int'(PIX_READY), 0);
        check_val({pfx, "_x"}, int'(X), 0);
        check_val({pfx, "_y"}, int'(Y), 0);
        check_val({pfx, "_imgin_nonzero"}, int'(|IMGIN), 0);
    endtask

    task automatic wait_fd(input int n);
        for (int i = 0; i < Bound && fd_cnt < n; i++) @(negedge CLK);
        check_val("frame_done_seen", int'(fd_cnt >= n), 1);
    endtask

    initial begin
        int c1, n0, dcyc;
        bit seen;
        nRST = 1'b0; DONE = 1'b0; PIX_VALID = 1'b0; PIX_DATA = 8'h00;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check_idle_outputs("rst");

        // Release: still IDLE this cycle, ready from the next.
        @(posedge CLK); #1; nRST = 1'b1;
        @(negedge CLK);
        check_val("rel_ready_t", int'(PIX_READY), 0);
        @(negedge CLK);
        check_val("rel_ready_t1", int'(PIX_READY), 1);
        @(posedge CLK); #1; feed_en = 1; auto_done = 1;

        // Frame 1: ramp, continuous feed.
        for (int i = 0; i < Bound && start_cnt < 1; i++) @(negedge CLK);
        check_val("fill_to_start", first_start_cyc - acc140_cyc, 2);
        c1 = first_start_cyc;
        for (int i = 0; i < Bound && start_cnt < 2; i++) @(negedge CLK);
        check_val("done_to_start", last_start_cyc - c1, 4);
        wait_fd(1);
        gap_en = 1;
        repeat (3) @(negedge CLK);
        check_val("f1_starts", start_cnt, 576);
        check_val("f1_frame_done", fd_cnt, 1);
        check_val("f1_order_err", order_err, 0);
        check_val("f1_win_err", win_err, 0);
        check_val("w00_b0", int'(w00_b0), int'(ExpW00B0));
        check_val("w00_b5", int'(w00_b5), int'(ExpW00B5));
        check_val("w00_b24", int'(w00_b24), int'(ExpW00B24));
        check_val("wlast_b0", int'(wl_b0), int'(ExpLastB0));
        check_val("wlast_b24", int'(wl_b24), int'(ExpLastB24));
        check_val("refill_count", refill_last, 28);
        check_val("w10_b24", int'(w10_b24), int'(ExpW10B24));
        check_val("refill_to_start", w10_cyc - refill_acc_cyc, 2);
        check_val("fd_latency", fd_cyc - last_start_cyc, 3);
        check_val("ready_at_fd", int'(rdy_at_fd), 0);
        check_val("ready_after_fd", int'(rdy_after_fd), 1);

        // Frame 2: back-to-back, gapped feed.
        wait_fd(2);
        auto_done = 0;
        gap_en = 0;
        check_val("f2_starts", start_cnt, 1152);
        check_val("f2_frame_done", fd_cnt, 2);
        check_val("f2_order_err", order_err, 0);
        check_val("f2_win_err", win_err, 0);
        check_val("f2_refill_count", refill_last, 28);

        // Frame 3: DONE only in the STRT cycle is lost.
        seen = 0;
        for (int i = 0; i < Bound; i++) begin
            @(negedge CLK);
            if (START) begin
                seen = 1;
                break;
            end
        end
        check_val("strt_seen", int'(seen), 1);
        DONE = 1'b1;
        @(posedge CLK); #1; DONE = 1'b0;
        n0 = start_cnt;
        repeat (6) @(negedge CLK);
        check_val("strt_done_lost", start_cnt - n0, 0);
        @(posedge CLK); #1; DONE = 1'b1;
        @(negedge CLK); dcyc = cyc;
        @(posedge CLK); #1; DONE = 1'b0; auto_done = 1;
        for (int i = 0; i < Bound && start_cnt <= n0; i++) @(negedge CLK);
        check_val("wait_done_to_start", last_start_cyc - dcyc, 2);
        check_val("wait_adv_x", int'(last_x), 0);
        check_val("wait_adv_y", int'(last_y), 1);

        // Mid-frame reset during WAIT at (7,11).
        seen = 0;
        for (int i = 0; i < Bound; i++) begin
            @(negedge CLK);
            if (START && X == 5'd7 && Y == 5'd11) begin
                seen = 1;
                break;
            end
        end
        check_val("w7_11_seen", int'(seen), 1);
        @(posedge CLK); #1; nRST = 1'b0; auto_done = 0; DONE = 1'b0;
        @(posedge CLK); #1; nRST = 1'b1;
        pix_idx = 0; start_cnt = 0; fd_cnt = 0; win_err = 0; order_err = 0; ex = 0; ey = 0;
        w00_b0 = 8'hEE; w00_b5 = 8'hEE; w00_b24 = 8'hEE;
        @(negedge CLK);
        check_idle_outputs("midrst");
        auto_done = 1;
        wait_fd(1);
        check_val("r_fill_to_start", first_start_cyc - acc140_cyc, 2);
        check_val("r_starts", start_cnt, 576);
        check_val("r_order_err", order_err, 0);
        check_val("r_win_err", win_err, 0);
        check_val("r_w00_b0", int'(w00_b0), int'(ExpW00B0));
        check_val("r_w00_b5", int'(w00_b5), int'(ExpW00B5));
        check_val("r_w00_b24", int'(w00_b24), int'(ExpW00B24));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
